// File: rtl/mcb_port_bram.sv
// mcb_port_bram: single-port memory controller "MCB user port" model backed by
// on-chip block RAM. Commands, write data and read data pass through FIFOs; an
// executor FSM runs one command at a time in acceptance order.
//
// Ports
//   clk, reset_n                       clock, async active-low reset
//   calib_done                         port ready (CALIB_CYCLES after reset release)
//   cmd_en/cmd_instr/cmd_byte_addr/cmd_bl, cmd_full   command push interface
//   wr_en/wr_data/wr_mask, wr_full     write-data push (mask bit 1 keeps byte)
//   rd_en, rd_data, rd_empty           first-word-fall-through read-data pop
//   wr_err, rd_err                     sticky error flags
module mcb_port_bram #(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned DATA_DEPTH   = 64,
  parameter int unsigned CALIB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        calib_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [29:0] cmd_byte_addr,
  input  logic [5:0]  cmd_bl,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask,
  output logic        wr_full,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_empty,
  output logic        wr_err,
  output logic        rd_err
);

  localparam int unsigned AW   = (MEM_WORDS > 1)  ? $clog2(MEM_WORDS)  : 1;
  localparam int unsigned CPW  = (CMD_DEPTH > 1)  ? $clog2(CMD_DEPTH)  : 1;
  localparam int unsigned CCW  = $clog2(CMD_DEPTH + 1);
  localparam int unsigned DPW  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned DCW  = $clog2(DATA_DEPTH + 1);
  localparam int unsigned CALW = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned BLW  = 7;

  typedef struct packed {
    logic [2:0]    instr;
    logic [AW-1:0] waddr;
    logic [5:0]    bl;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_word_t;

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST} state_t;

  // Byte-offset bits and address bits above the memory size carry no meaning.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cmd_byte_addr[1:0], cmd_byte_addr[29:AW+2]};

  // ---------------------------------------------------------------- calibration
  logic [CALW-1:0] cal_cnt;
  logic            calib_nxt;

  assign calib_nxt = calib_done || (cal_cnt == CALW'(CALIB_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cal_cnt    <= '0;
      calib_done <= 1'b0;
    end else begin
      calib_done <= calib_nxt;
      if (!calib_done) cal_cnt <= cal_cnt + CALW'(1);
    end
  end

  // ---------------------------------------------------------------- command FIFO
  cmd_t           cmd_mem [CMD_DEPTH];
  logic [CPW-1:0] cmd_wptr, cmd_rptr;
  logic [CCW-1:0] cmd_count, cmd_count_nxt;
  logic           cmd_push, cmd_pop;
  cmd_t           cmd_head;

  assign cmd_push      = cmd_en && !cmd_full;
  assign cmd_head      = cmd_mem[cmd_rptr];
  assign cmd_count_nxt = cmd_count + CCW'(cmd_push) - CCW'(cmd_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_wptr  <= '0;
      cmd_rptr  <= '0;
      cmd_count <= '0;
      cmd_full  <= 1'b1;
    end else begin
      if (cmd_push) cmd_wptr <= (cmd_wptr == CPW'(CMD_DEPTH - 1)) ? '0 : cmd_wptr + CPW'(1);
      if (cmd_pop)  cmd_rptr <= (cmd_rptr == CPW'(CMD_DEPTH - 1)) ? '0 : cmd_rptr + CPW'(1);
      cmd_count <= cmd_count_nxt;
      cmd_full  <= !calib_nxt || (cmd_count_nxt == CCW'(CMD_DEPTH));
    end
  end

  // Command storage: byte address reduced to a word address on entry.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wptr] <= '{instr: cmd_instr, waddr: cmd_byte_addr[AW+1:2], bl: cmd_bl};
    end
  end

  // ---------------------------------------------------------------- write-data FIFO
  wr_word_t       wr_mem [DATA_DEPTH];
  logic [DPW-1:0] wr_wptr, wr_rptr;
  logic [DCW-1:0] wr_count, wr_count_nxt;
  logic           wr_push, wr_pop;
  wr_word_t       wr_head;

  assign wr_push      = wr_en && !wr_full;
  assign wr_head      = wr_mem[wr_rptr];
  assign wr_count_nxt = wr_count + DCW'(wr_push) - DCW'(wr_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_wptr  <= '0;
      wr_rptr  <= '0;
      wr_count <= '0;
      wr_full  <= 1'b0;
    end else begin
      if (wr_push) wr_wptr <= (wr_wptr == DPW'(DATA_DEPTH - 1)) ? '0 : wr_wptr + DPW'(1);
      if (wr_pop)  wr_rptr <= (wr_rptr == DPW'(DATA_DEPTH - 1)) ? '0 : wr_rptr + DPW'(1);
      wr_count <= wr_count_nxt;
      wr_full  <= (wr_count_nxt == DCW'(DATA_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wr_wptr] <= '{mask: wr_mask, data: wr_data};
  end

  // ---------------------------------------------------------------- executor FSM
  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [BLW-1:0] remain, remain_nxt;
  logic          mem_we, mem_re, bad_instr;
  logic          rd_vld;
  logic [DCW-1:0] rd_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      addr   <= '0;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      remain <= remain_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    remain_nxt = remain;
    cmd_pop    = 1'b0;
    wr_pop     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    bad_instr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_count != '0) begin
          cmd_pop    = 1'b1;
          addr_nxt   = cmd_head.waddr;
          remain_nxt = BLW'(cmd_head.bl) + BLW'(1);
          case (cmd_head.instr)
            3'b000:  state_nxt = WR_WAIT;
            3'b001:  state_nxt = RD_WAIT;
            default: bad_instr = 1'b1;
          endcase
        end
      end
      // Whole burst must be buffered so the write streams without stalls.
      WR_WAIT: begin
        if (32'(wr_count) >= 32'(remain)) state_nxt = WR_BURST;
      end
      WR_BURST: begin
        wr_pop     = 1'b1;
        mem_we     = 1'b1;
        addr_nxt   = addr + AW'(1);
        remain_nxt = remain - BLW'(1);
        if (remain == BLW'(1)) state_nxt = IDLE;
      end
      // Reserve room for the whole burst plus a word still in the RAM pipe.
      RD_WAIT: begin
        if (32'(DATA_DEPTH) - 32'(rd_count) >= 32'(remain) + 32'(rd_vld)) state_nxt = RD_BURST;
      end
      RD_BURST: begin
        mem_re     = 1'b1;
        addr_nxt   = addr + AW'(1);
        remain_nxt = remain - BLW'(1);
        if (remain == BLW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- block RAM
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] mem_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head.mask[b]) mem[addr][8*b +: 8] <= wr_head.data[8*b +: 8];
      end
    end
    if (mem_re) mem_q <= mem[addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_vld <= 1'b0;
    else          rd_vld <= mem_re;
  end

  // ---------------------------------------------------------------- read-data FIFO
  logic [31:0]    rd_mem [DATA_DEPTH];
  logic [DPW-1:0] rd_wptr, rd_rptr, rd_rptr_inc;
  logic [DCW-1:0] rd_count_nxt;
  logic           rd_push, rd_pop;
  logic [31:0]    rd_head_nxt;

  assign rd_push      = rd_vld;
  assign rd_pop       = rd_en && !rd_empty;
  assign rd_count_nxt = rd_count + DCW'(rd_push) - DCW'(rd_pop);
  assign rd_rptr_inc  = (rd_rptr == DPW'(DATA_DEPTH - 1)) ? '0 : rd_rptr + DPW'(1);

  // Registered head word: a push into an (about to be) empty FIFO bypasses storage.
  always_comb begin
    rd_head_nxt = rd_data;
    if (rd_count == '0) begin
      if (rd_push) rd_head_nxt = mem_q;
    end else if (rd_pop) begin
      if (rd_count == DCW'(1)) begin
        if (rd_push) rd_head_nxt = mem_q;
      end else begin
        rd_head_nxt = rd_mem[rd_rptr_inc];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wptr  <= '0;
      rd_rptr  <= '0;
      rd_count <= '0;
      rd_empty <= 1'b1;
      rd_data  <= '0;
    end else begin
      if (rd_push) rd_wptr <= (rd_wptr == DPW'(DATA_DEPTH - 1)) ? '0 : rd_wptr + DPW'(1);
      if (rd_pop)  rd_rptr <= rd_rptr_inc;
      rd_count <= rd_count_nxt;
      rd_empty <= (rd_count_nxt == '0);
      rd_data  <= rd_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wptr] <= mem_q;
  end

  // ---------------------------------------------------------------- sticky errors
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      if ((wr_en && wr_full) || bad_instr) wr_err <= 1'b1;
      if (rd_en && rd_empty)               rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcb_port_bram.sv
// tb_mcb_port_bram: scenario tasks drive commands/data; expected read words are
// pushed to a scoreboard from a byte-masked memory model and compared on pop.
module tb_mcb_port_bram;

  localparam int unsigned MW = 4096;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        calib_done;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [29:0] cmd_byte_addr;
  logic [5:0]  cmd_bl;
  logic        cmd_full;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        wr_err;
  logic        rd_err;

  always #5 clk = ~clk;

  mcb_port_bram #(.MEM_WORDS(MW), .CMD_DEPTH(4), .DATA_DEPTH(64), .CALIB_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_byte_addr(cmd_byte_addr), .cmd_bl(cmd_bl),
    .cmd_full(cmd_full), .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .wr_err(wr_err), .rd_err(rd_err)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];
  logic [31:0] model [int unsigned];
  logic [35:0] wq [$];  // {mask, data}

  task automatic drive_idle();
    cmd_en = 1'b0; cmd_instr = '0; cmd_byte_addr = '0; cmd_bl = '0;
    wr_en = 1'b0; wr_data = '0; wr_mask = '0; rd_en = 1'b0;
  endtask

  task automatic issue_cmd(input logic [2:0] instr, input int unsigned baddr, input int unsigned bl);
    int n = 0;
    while (cmd_full && n < 200) begin @(negedge clk); n++; end
    if (cmd_full) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout cmd_full=%b required 0", cmd_full);
    end
    cmd_en = 1'b1; cmd_instr = instr; cmd_byte_addr = 30'(baddr); cmd_bl = 6'(bl);
    @(negedge clk);
    cmd_en = 1'b0;
  endtask

  task automatic push_words();
    foreach (wq[i]) begin
      wr_en = 1'b1; wr_mask = wq[i][35:32]; wr_data = wq[i][31:0];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // Apply the queued words to the model and issue the write command.
  task automatic commit_write(input int unsigned baddr);
    int unsigned w = (baddr >> 2) % MW;
    foreach (wq[i]) begin
      int unsigned a = (w + i) % MW;
      logic [31:0] v = model.exists(a) ? model[a] : 32'h0;
      for (int b = 0; b < 4; b++) if (!wq[i][32+b]) v[8*b +: 8] = wq[i][8*b +: 8];
      model[a] = v;
    end
    issue_cmd(3'b000, baddr, wq.size() - 1);
  endtask

  task automatic send_read(input int unsigned baddr, input int unsigned n);
    int unsigned w = (baddr >> 2) % MW;
    for (int unsigned i = 0; i < n; i++) sb.push_back(model[(w + i) % MW]);
    issue_cmd(3'b001, baddr, n - 1);
  endtask

  task automatic pop_word(output logic [31:0] d);
    int n = 0;
    while (rd_empty && n < 300) begin @(negedge clk); n++; end
    if (rd_empty) begin
      checks++; errors++;
      $display("FAIL read_timeout rd_empty=%b required 0", rd_empty);
      d = 'x;
    end else begin
      d = rd_data; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; drive_idle(); sb.delete();
    repeat (3) @(negedge clk);
    checks++; if (calib_done !== 1'b0) begin errors++; $display("FAIL rst_calib_done got %b need 0", calib_done); end
    checks++; if (cmd_full !== 1'b1)   begin errors++; $display("FAIL rst_cmd_full got %b need 1", cmd_full); end
    checks++; if (wr_full !== 1'b0)    begin errors++; $display("FAIL rst_wr_full got %b need 0", wr_full); end
    checks++; if (rd_empty !== 1'b1)   begin errors++; $display("FAIL rst_rd_empty got %b need 1", rd_empty); end
    checks++; if (rd_data !== 32'h0)   begin errors++; $display("FAIL rst_rd_data got %h need 0", rd_data); end
    checks++; if (wr_err !== 1'b0)     begin errors++; $display("FAIL rst_wr_err got %b need 0", wr_err); end
    checks++; if (rd_err !== 1'b0)     begin errors++; $display("FAIL rst_rd_err got %b need 0", rd_err); end
    reset_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      checks++;
      if (calib_done !== (k >= 16)) begin errors++; $display("FAIL calib_cycle%0d got %b need %b", k, calib_done, k >= 16); end
      checks++;
      if (cmd_full !== (k < 16)) begin errors++; $display("FAIL cmd_full_cycle%0d got %b need %b", k, cmd_full, k < 16); end
    end
  endtask

  task automatic test_burst();
    logic [31:0] d, e;
    int lat = 0;
    wq.delete();
    for (int i = 0; i < 32; i++) wq.push_back({4'h0, 32'(i)});
    push_words(); commit_write(0);
    repeat (45) @(negedge clk);
    for (int i = 0; i < 32; i++) sb.push_back(model[i]);
    issue_cmd(3'b001, 0, 31);
    while (rd_empty && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat != 4) begin errors++; $display("FAIL read_latency got %0d need 4", lat); end
    for (int i = 0; i < 32; i++) begin
      pop_word(d); e = sb.pop_front(); checks++;
      if (d !== e || d !== 32'(i)) begin errors++; $display("FAIL burst_word%0d got %h need %h", i, d, e); end
    end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL burst_drained rd_empty got %b need 1", rd_empty); end
  endtask

  task automatic test_mask();
    logic [31:0] d, e;
    wq.delete(); wq.push_back({4'b0000, 32'hAABBCCDD}); push_words(); commit_write(32'h10);
    wq.delete(); wq.push_back({4'b0101, 32'h11223344}); push_words(); commit_write(32'h10);
    send_read(32'h10, 1);
    pop_word(d); e = sb.pop_front(); checks++;
    if (d !== e || d !== 32'h11BB33DD) begin errors++; $display("FAIL mask_merge got %h need 11bb33dd", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d, e;
    wq.delete();
    for (int i = 1; i <= 4; i++) wq.push_back({4'h0, 32'(i)});
    push_words(); commit_write((MW - 2) * 4);
    send_read(0, 2);
    for (int i = 0; i < 2; i++) begin
      pop_word(d); e = sb.pop_front(); checks++;
      if (d !== e || d !== 32'(i + 3)) begin errors++; $display("FAIL wrap_low%0d got %h need %h", i, d, 32'(i + 3)); end
    end
    send_read((MW - 2) * 4 + 3, 4);  // low address bits ignored
    for (int i = 0; i < 4; i++) begin
      pop_word(d); e = sb.pop_front(); checks++;
      if (d !== e) begin errors++; $display("FAIL wrap_burst%0d got %h need %h", i, d, e); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] d, e;
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL pre_wr_err got %b need 0", wr_err); end
    wq.delete();
    for (int i = 0; i < 64; i++) wq.push_back({4'h0, 32'h100 + 32'(i)});
    push_words();
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL fifo_full got %b need 1", wr_full); end
    checks++; if (wr_err !== 1'b0)  begin errors++; $display("FAIL full_no_err got %b need 0", wr_err); end
    wr_en = 1'b1; wr_data = 32'hDEADBEEF; wr_mask = 4'h0;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL overflow_wr_err got %b need 1", wr_err); end
    commit_write(32'h400);
    send_read(32'h400, 64);
    for (int i = 0; i < 64; i++) begin
      pop_word(d); e = sb.pop_front(); checks++;
      if (d !== e) begin errors++; $display("FAIL full_burst%0d got %h need %h", i, d, e); end
    end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL pre_rd_err got %b need 0", rd_err); end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++; if (rd_err !== 1'b1)   begin errors++; $display("FAIL underflow_rd_err got %b need 1", rd_err); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL underflow_empty got %b need 1", rd_empty); end
  endtask

  task automatic test_bad_instr();
    logic [31:0] d, e;
    reset_n = 1'b0; drive_idle(); sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    issue_cmd(3'b111, 32'h10, 0);
    repeat (4) @(negedge clk);
    checks++; if (wr_err !== 1'b1)   begin errors++; $display("FAIL bad_instr_wr_err got %b need 1", wr_err); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL bad_instr_no_data got %b need 1", rd_empty); end
    send_read(32'h10, 1);
    pop_word(d); e = sb.pop_front(); checks++;
    if (d !== e) begin errors++; $display("FAIL retained_after_reset got %h need %h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back({4'h0, 32'hC0DE0000 + 32'(i)});
    push_words(); commit_write(32'h10);
    send_read(32'h10, 4);
    for (int i = 0; i < 4; i++) begin
      pop_word(d); e = sb.pop_front(); checks++;
      if (d !== e) begin errors++; $display("FAIL b2b_word%0d got %h need %h", i, d, e); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d, e;
    int n = 0;
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back({4'h0, 32'h5A000000 + 32'(i)});
    push_words(); commit_write(32'hC00);
    send_read(32'hC00, 16);
    while (rd_empty && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (rd_empty !== 1'b1)   begin errors++; $display("FAIL abort_rd_empty got %b need 1", rd_empty); end
    checks++; if (rd_data !== 32'h0)   begin errors++; $display("FAIL abort_rd_data got %h need 0", rd_data); end
    checks++; if (calib_done !== 1'b0) begin errors++; $display("FAIL abort_calib got %b need 0", calib_done); end
    checks++; if (cmd_full !== 1'b1)   begin errors++; $display("FAIL abort_cmd_full got %b need 1", cmd_full); end
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    send_read(32'hC00, 16);
    n = 0;
    while (rd_empty && n < 20) begin @(negedge clk); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL abort_idle_latency got %0d need 4", n); end
    for (int i = 0; i < 16; i++) begin
      pop_word(d); e = sb.pop_front(); checks++;
      if (d !== e) begin errors++; $display("FAIL abort_reread%0d got %h need %h", i, d, e); end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_mask();
    test_wrap();
    test_errors();
    test_bad_instr();
    test_back_to_back();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mcb_port_bram.md
MCB_PORT_BRAM -- requirements
Module: mcb_port_bram

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, memory depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries.
REQ-003 SHALL have parameter DATA_DEPTH, default 64, entries in each of the write-data and read-data FIFOs.
REQ-004 SHALL have parameter CALIB_CYCLES, default 16, cycles from reset release to calib_done.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports are clk and reset_n.
REQ-006 clk  in  1  sole clock; all logic rising-edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 calib_done  out  1  port ready.
REQ-009 cmd_en  in  1  command push; cmd_instr  in  3  000=write, 001=read; cmd_byte_addr  in  30  byte address; cmd_bl  in  6  burst length minus 1.
REQ-010 cmd_full  out  1  command FIFO cannot accept.
REQ-011 wr_en  in  1  write-data push; wr_data  in  32; wr_mask  in  4  bit=1 suppresses that byte; wr_full  out  1.
REQ-012 rd_en  in  1  read-data pop; rd_data  out  32  head word; rd_empty  out  1.
REQ-013 wr_err  out  1  sticky push-while-full or bad-instr flag; rd_err  out  1  sticky pop-while-empty flag.

Function
REQ-014 calib_done SHALL rise exactly CALIB_CYCLES cycles after reset_n deasserts and stay high until the next reset.
REQ-015 cmd_full SHALL be 1 while calib_done=0 or the command FIFO holds CMD_DEPTH entries.
REQ-016 A command SHALL be accepted on an edge with cmd_en=1 and cmd_full=0; cmd_en while cmd_full=1 is ignored.
REQ-017 Write data SHALL be accepted on an edge with wr_en=1 and wr_full=0; wr_en while wr_full=1 drops the word and sets wr_err.
REQ-018 Read-data FIFO SHALL be first-word-fall-through: rd_data valid whenever rd_empty=0; rd_en pops; rd_en while rd_empty=1 is ignored and sets rd_err.
REQ-019 Simultaneous push and pop on any FIFO SHALL both take effect; occupancy unchanged.
REQ-020 Executor FSM states: IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST.
REQ-021 IDLE: if command FIFO non-empty, pop it, latch word address = cmd_byte_addr[29:2] mod MEM_WORDS and count = cmd_bl+1; instr 000 -> WR_WAIT, 001 -> RD_WAIT, other -> discard, set wr_err, stay IDLE.
REQ-022 WR_WAIT: advance to WR_BURST once write-data FIFO holds >= count words.
REQ-023 WR_BURST: one word per cycle popped and written to memory at address, bytes with mask bit 1 unchanged; address increments with wrap at MEM_WORDS; after count words -> IDLE.
REQ-024 RD_WAIT: advance to RD_BURST once read-data FIFO free space >= count plus in-flight words.
REQ-025 RD_BURST: one memory read per cycle, 1-cycle memory latency, each result pushed into read-data FIFO; address wraps at MEM_WORDS; after count reads issued -> IDLE, in-flight word still lands.
REQ-026 Idle executor, space available: first read word SHALL make rd_empty=0 exactly 4 cycles after the cmd_en accept edge; subsequent words one per cycle.
REQ-027 Commands SHALL execute strictly in acceptance order; a read after a write to the same address returns the written data.
REQ-028 cmd_byte_addr[1:0] SHALL be ignored.

Reset
REQ-029 On reset_n=0: FSM=IDLE, all FIFOs empty, calib_done=0, cmd_full=1, wr_full=0, rd_empty=1, rd_data=0, wr_err=0, rd_err=0, calibration counter=0.
REQ-030 Reset mid-burst SHALL abort the burst immediately; memory contents are not cleared; words already written remain.

Verification
REQ-031 Reset release -> calib_done=0 for 16 cycles, 1 at cycle 16; cmd_full follows inverse until then.
REQ-032 Push 32 words 0..31, write cmd addr 0x000 bl=31, then read cmd addr 0x000 bl=31 -> 32 words 0..31 in order, rd_empty=0 4 cycles after read cmd accept.
REQ-033 Write 0xAABBCCDD to addr 0x10 mask 0000, then 0x11223344 mask 0101 -> read gives 0x11BB33DD.
REQ-034 Write cmd bl=3 at byte addr (MEM_WORDS-2)*4 with data 1,2,3,4 -> words 3,4 stored at word 0,1; read back matches.
REQ-035 Fill write FIFO to 64, push once more -> word dropped, wr_err=1; pop empty read FIFO -> rd_err=1; cmd_instr=111 -> discarded, wr_err=1.
REQ-036 Assert reset_n=0 mid read burst -> rd_empty=1, FSM IDLE, memory prior contents readable after recalibration.
